// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data load/store.
// Data has priority; a starvation counter forces a fetch after STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_wen,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  // state  | meaning
  // IDLE   | no access in flight; arbitrate on every edge
  // IF_ACC | fetch access in flight, cnt counts latency cycles
  // D_ACC  | data access in flight, cnt counts latency cycles
  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  state_t        state, state_nxt;
  logic [2:0]    cnt;
  logic [SW-1:0] starve_cnt;
  logic          d_we_q;
  logic          grant_if, grant_d, acc_done, starved;

  assign starved  = (starve_cnt == SW'(STARVE_MAX));
  assign busy     = (state != IDLE);
  assign if_stall = if_req & ~if_ack;

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    acc_done  = (state != IDLE) && (cnt == 3'(LAT));
    case (state)
      IDLE: begin
        if (if_req && (!d_req || starved)) begin
          grant_if  = 1'b1;
          state_nxt = IF_ACC;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = D_ACC;
        end
      end
      IF_ACC, D_ACC: begin
        if (acc_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      starve_cnt <= '0;
      d_we_q     <= 1'b0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wen      <= 1'b1;
    end else begin
      // acks and the write strobe are single-cycle pulses by default
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      m_wen  <= 1'b1;
      if (grant_if) begin
        m_addr <= if_addr;
        cnt    <= 3'd1;
      end else if (grant_d) begin
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_wen   <= ~d_we;
        d_we_q  <= d_we;
        cnt     <= 3'd1;
      end else if (state != IDLE) begin
        if (acc_done) begin
          cnt <= '0;
          if (state == IF_ACC) begin
            if_rdata <= m_rdata;
            if_ack   <= 1'b1;
          end else begin
            if (!d_we_q) d_rdata <= m_rdata;
            d_ack <= 1'b1;
          end
        end else begin
          cnt <= cnt + 3'd1;
        end
      end

      if (state == IDLE) begin
        if (grant_if || !if_req)      starve_cnt <= '0;
        else if (grant_d && !starved) starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (LAT=2, STARVE_MAX=4).
// Memory model returns (address ^ 16'hA5D3) one edge after the address is registered.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [15:0] KEY = 16'hA5D3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] if_rdata, d_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  logic          if_ack, if_stall, d_ack, m_wen, busy;
  logic [AW-1:0] addr_d;

  int n_pass  = 0;
  int n_total = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) addr_d <= m_addr;
  assign m_rdata = addr_d ^ KEY;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] seq;
    int         n_acks;
    logic       overlap;

    rst = 1'b1;
    if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
    if_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
    tick();
    tick();
    check("rst_if_ack",   32'(if_ack),   32'd0);
    check("rst_d_ack",    32'(d_ack),    32'd0);
    check("rst_if_rdata", 32'(if_rdata), 32'd0);
    check("rst_d_rdata",  32'(d_rdata),  32'd0);
    check("rst_m_addr",   32'(m_addr),   32'd0);
    check("rst_m_wdata",  32'(m_wdata),  32'd0);
    check("rst_m_wen",    32'(m_wen),    32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // single fetch
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    check("f_busy_e0",   32'(busy),     32'd1);
    check("f_maddr_e0",  32'(m_addr),   32'h0010);
    check("f_stall_e0",  32'(if_stall), 32'd1);
    tick();
    check("f_ack_e1",    32'(if_ack),   32'd0);
    check("f_stall_e1",  32'(if_stall), 32'd1);
    tick();
    check("f_ack_e2",    32'(if_ack),   32'd1);
    check("f_rdata_e2",  32'(if_rdata), 32'hA5C3);
    check("f_stall_e2",  32'(if_stall), 32'd0);
    check("f_busy_e2",   32'(busy),     32'd0);
    if_req = 1'b0;
    tick();
    check("f_ack_e3",    32'(if_ack),   32'd0);
    check("f_rdata_hold",32'(if_rdata), 32'hA5C3);

    // single store
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
    tick();
    check("s_wen_e0",    32'(m_wen),   32'd0);
    check("s_maddr_e0",  32'(m_addr),  32'h0040);
    check("s_wdata_e0",  32'(m_wdata), 32'h1234);
    tick();
    check("s_wen_e1",    32'(m_wen),   32'd1);
    check("s_ack_e1",    32'(d_ack),   32'd0);
    tick();
    check("s_ack_e2",    32'(d_ack),   32'd1);
    check("s_rdata_e2",  32'(d_rdata), 32'd0);
    check("s_wen_e2",    32'(m_wen),   32'd1);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check("s_ack_e3",    32'(d_ack),   32'd0);

    // simultaneous fetch and load: data first
    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    tick();
    check("sim_maddr_d", 32'(m_addr), 32'h0040);
    check("sim_wen_ld",  32'(m_wen),  32'd1);
    tick();
    tick();
    check("sim_d_ack",   32'(d_ack),   32'd1);
    check("sim_if_ack0", 32'(if_ack),  32'd0);
    check("sim_d_rdata", 32'(d_rdata), 32'hA593);
    d_req = 1'b0;
    tick();
    check("sim_d_ack_off", 32'(d_ack),  32'd0);
    check("sim_maddr_if",  32'(m_addr), 32'h0020);
    check("sim_stall",     32'(if_stall), 32'd1);
    tick();
    tick();
    check("sim_if_ack",   32'(if_ack),   32'd1);
    check("sim_d_ack1",   32'(d_ack),    32'd0);
    check("sim_if_rdata", 32'(if_rdata), 32'hA5F3);
    if_req = 1'b0;
    tick();

    // starvation: continuous data with a waiting fetch
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080;
    if_req = 1'b1; if_addr = 16'h0030;
    seq = '0; n_acks = 0; overlap = 1'b0;
    for (int c = 0; c < 40 && n_acks < 6; c++) begin
      tick();
      if (if_ack && d_ack) overlap = 1'b1;
      if (if_ack || d_ack) begin
        seq[n_acks] = if_ack;
        n_acks++;
      end
      if (if_ack) if_req = 1'b0;
    end
    check("starve_nacks",   32'(n_acks),  32'd6);
    check("starve_seq",     32'(seq),     32'b010000);
    check("starve_overlap", 32'(overlap), 32'd0);
    check("starve_rdata",   32'(d_rdata), 32'hA553);
    d_req = 1'b0;
    tick();
    check("starve_idle", 32'(busy), 32'd0);

    // reset in the middle of a load
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
    tick();
    check("mr_busy_e0", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("mr_busy",  32'(busy),   32'd0);
    check("mr_d_ack", 32'(d_ack),  32'd0);
    check("mr_wen",   32'(m_wen),  32'd1);
    check("mr_maddr", 32'(m_addr), 32'd0);
    rst = 1'b0;
    tick();
    check("mr_regrant", 32'(m_addr), 32'h0050);
    check("mr_d_ack_g", 32'(d_ack),  32'd0);
    tick();
    tick();
    check("mr_d_ack2",  32'(d_ack),   32'd1);
    check("mr_d_rdata", 32'(d_rdata), 32'hA583);
    d_req = 1'b0;
    tick();
    check("mr_d_ack3",  32'(d_ack),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 16-bit memory between the instruction-fetch requester and the data (load/store) requester of the 5-stage pipeline.
- Sequences multi-cycle memory accesses with a req/ack handshake and generates the fetch stall used to freeze PC and IF/ID.
- Data accesses have priority. A starvation counter guarantees forward progress for fetch.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- LAT, 2, memory access latency in cycles; legal range 1..7.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  AW  fetch address; stable while if_req high.
- if_rdata  out  DW  fetched instruction; valid in the if_ack cycle and held until the next fetch completes.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  combinational, equals if_req & ~if_ack; drives the PC/IF-ID stall.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load; sampled at grant.
- d_addr  in  AW  data address; sampled at grant.
- d_wdata  in  DW  store data; sampled at grant.
- d_rdata  out  DW  load data; valid in the d_ack cycle and held.
- d_ack  out  1  one-cycle completion pulse for data.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_wen  out  1  memory write enable, active-low (1 = no write).
- m_rdata  in  DW  memory read data, valid LAT cycles after m_addr is presented.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset values (at any rising edge with rst=1, including mid-access):
  - State IDLE, cnt=0, starve_cnt=0.
  - if_ack=0, d_ack=0, if_rdata=0, d_rdata=0.
  - m_addr=0, m_wdata=0, m_wen=1, busy=0.
  - An in-flight access is abandoned; no ack is issued for it.
- States: IDLE, IF_ACC, D_ACC.
- Arbitration in IDLE, evaluated at each edge:
  - Grant fetch if if_req=1 and (d_req=0 or starve_cnt==STARVE_MAX).
  - Otherwise grant data if d_req=1.
  - Otherwise stay in IDLE.
- Starvation counter:
  - On a data grant with if_req=1: starve_cnt increments, saturating at STARVE_MAX.
  - On a fetch grant, or any IDLE edge with if_req=0: starve_cnt clears to 0.
- Grant edge E0:
  - Register the granted address into m_addr; register d_wdata into m_wdata for data grants.
  - Set cnt=1 and move to IF_ACC or D_ACC.
  - For a store, m_wen=0 for exactly the cycle following E0, then returns to 1.
- Edges E1..E(LAT-1): cnt increments; m_addr is held.
- Edge E_LAT:
  - Capture m_rdata into if_rdata or d_rdata (loads and fetches only; d_rdata is unchanged on a store).
  - Pulse the matching ack for one cycle and return to IDLE.
- When LAT=1, the access and ack edge coincide at E1.
- Edge E_LAT+1:
  - The ack returns to 0.
  - The arbiter is in IDLE and re-arbitrates; a req still high here is treated as a new request.
- Throughput: one access per LAT+1 cycles.
- Request handling during an access:
  - Requests arriving during an access wait. The waiting fetch keeps if_stall high.
  - A requester dropping req before its ack has no effect; the access completes and the ack still pulses.
- busy is high in IF_ACC and D_ACC, and low in IDLE.
- The two acks are never high in the same cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with random reqs -> all outputs at reset values, m_wen=1, busy=0.
- Single fetch, LAT=2: if_req=1, if_addr=0x0010, memory returns 0xA5C3 -> if_ack high in the 3rd cycle after grant edge, if_rdata=0xA5C3, if_stall low only in the ack cycle.
- Single store: d_req=1, d_we=1, d_addr=0x0040, d_wdata=0x1234 -> m_wen=0 for exactly one cycle with m_addr=0x0040 and m_wdata=0x1234; d_ack pulses once; d_rdata unchanged.
- Simultaneous requests: if_req and d_req rise in the same cycle -> data is served first (d_ack), then fetch (if_ack) LAT+1 cycles later; acks never overlap.
- Starvation: d_req held high continuously with if_req high, STARVE_MAX=4 -> exactly 4 d_acks, then 1 if_ack, then data resumes.
- Reset mid-access: rst asserted at cnt=1 of a load -> no d_ack, state IDLE next cycle, m_wen=1; the held request is re-granted after rst falls.
